tiny8_multicycle_ctrl: RTL and testbench

//  Parametrised multi-cycle control FSM for the tiny8 datapath. Sequences fetch (1..IR_BYTES bytes),

---
 rtl/tiny8_multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tiny8_multicycle_ctrl.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny8_multicycle_ctrl.sv
// tiny8 multi-cycle control FSM: fetch (1..IR_BYTES bytes), decode, execute and
// memory phases with a memory-wait timeout, plus absorbing HALT and FAULT states.
module tiny8_multicycle_ctrl #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned IR_BYTES    = 1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic                load_pc,
    output logic                load_acc,
    output logic                load_regfile,
    output logic                load_ir,
    output logic [1:0]          ir_byte_sel,
    output logic                pcmux_sel,
    output logic [1:0]          alumux1_sel,
    output logic                alumux2_sel,
    output logic [1:0]          addrmux_sel,
    output logic [2:0]          alu_op,
    output logic                instr_done,
    output logic                halted,
    output logic                fault
);

    localparam int unsigned WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [1:0]  LAST_BYTE = 2'(IR_BYTES - 1);

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_HALT, ST_FAULT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI,
        OP_STR, OP_LD, OP_ST, OP_JMP, OP_BRZ, OP_HALT
    } op_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASSA, ALU_PASSB
    } alu_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              op_illegal;
    logic              mem_phase;
    logic              timeout;

    assign op_illegal = (32'(opcode) > 32'd12);
    assign mem_phase  = (state == ST_FETCH) || (state == ST_MEMORY);
    // mem_resp in the timeout cycle still completes the request normally
    assign timeout    = (MEM_TIMEOUT != 0) && mem_phase && !mem_resp &&
                        (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // State, fetch byte counter and memory wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            byte_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        load_pc      = 1'b0;
        load_acc     = 1'b0;
        load_regfile = 1'b0;
        load_ir      = 1'b0;
        ir_byte_sel  = 2'd0;
        pcmux_sel    = 1'b0;
        alumux1_sel  = 2'd0;
        alumux2_sel  = 1'b0;
        addrmux_sel  = 2'd0;
        alu_op       = ALU_ADD;
        instr_done   = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        unique case (state)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    load_ir     = 1'b1;
                    ir_byte_sel = byte_cnt;
                    load_pc     = 1'b1;
                    if (byte_cnt != LAST_BYTE) begin
                        byte_cnt_nxt = byte_cnt + 2'd1;
                    end else begin
                        byte_cnt_nxt = '0;
                        state_nxt    = ST_DECODE;
                    end
                end else if (timeout) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (op_illegal) begin
                    state_nxt = ST_FAULT;
                end else begin
                    case (opcode[3:0])
                        OP_NOP: begin
                            instr_done = 1'b1;
                            state_nxt  = ST_FETCH;
                        end
                        OP_HALT: begin
                            instr_done = 1'b1;
                            state_nxt  = ST_HALT;
                        end
                        OP_LD, OP_ST: state_nxt = ST_MEMORY;
                        default:      state_nxt = ST_EXECUTE;
                    endcase
                end
            end
            ST_EXECUTE: begin
                instr_done = 1'b1;
                state_nxt  = ST_FETCH;
                case (opcode[3:0])
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        load_acc = 1'b1;
                        alu_op   = 3'(opcode[3:0] - 4'd1);
                    end
                    OP_LDI: begin
                        load_acc    = 1'b1;
                        alumux2_sel = 1'b1;
                        alu_op      = ALU_PASSB;
                    end
                    OP_STR: load_regfile = 1'b1;
                    OP_JMP: begin
                        load_pc   = 1'b1;
                        pcmux_sel = 1'b1;
                    end
                    OP_BRZ: begin
                        load_pc   = zero;
                        pcmux_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEMORY: begin
                addrmux_sel = 2'd1;
                if (opcode[3:0] == OP_ST) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_acc    = 1'b1;
                        alumux1_sel = 2'd2;
                        alu_op      = ALU_PASSA;
                    end
                end
                if (mem_resp) begin
                    instr_done = 1'b1;
                    state_nxt  = ST_FETCH;
                end else if (timeout) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default:  state_nxt = ST_FAULT;
        endcase

        // count only consecutive unanswered cycles within one request
        if ((MEM_TIMEOUT != 0) && mem_phase && !mem_resp && (state_nxt == state))
            wait_cnt_nxt = wait_cnt + 1'b1;
        else
            wait_cnt_nxt = '0;
    end

endmodule

// File: tb/tb_tiny8_multicycle_ctrl.sv
// Scoreboard bench for tiny8_multicycle_ctrl: three instances (IR_BYTES=1/MT=16,
// IR_BYTES=3/MT=16, IR_BYTES=1/MT=4) sharing clock and reset.
module tb_tiny8_multicycle_ctrl;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       load_pc;
        logic       load_acc;
        logic       load_regfile;
        logic       load_ir;
        logic [1:0] ir_byte_sel;
        logic       pcmux_sel;
        logic [1:0] alumux1_sel;
        logic       alumux2_sel;
        logic [1:0] addrmux_sel;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       halted;
        logic       fault;
    } out_t;

    typedef struct packed {
        logic [1:0] inst;
        out_t       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode[3];
    logic       zero[3];
    logic       mem_resp[3];
    logic       mem_read[3];
    logic       mem_write[3];
    logic       load_pc[3];
    logic       load_acc[3];
    logic       load_regfile[3];
    logic       load_ir[3];
    logic [1:0] ir_byte_sel[3];
    logic       pcmux_sel[3];
    logic [1:0] alumux1_sel[3];
    logic       alumux2_sel[3];
    logic [1:0] addrmux_sel[3];
    logic [2:0] alu_op[3];
    logic       instr_done[3];
    logic       halted[3];
    logic       fault[3];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tiny8_multicycle_ctrl #(
            .OPCODE_W   (4),
            .IR_BYTES   ((g == 1) ? 3 : 1),
            .MEM_TIMEOUT((g == 2) ? 4 : 16)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .opcode      (opcode[g]),
            .zero        (zero[g]),
            .mem_resp    (mem_resp[g]),
            .mem_read    (mem_read[g]),
            .mem_write   (mem_write[g]),
            .load_pc     (load_pc[g]),
            .load_acc    (load_acc[g]),
            .load_regfile(load_regfile[g]),
            .load_ir     (load_ir[g]),
            .ir_byte_sel (ir_byte_sel[g]),
            .pcmux_sel   (pcmux_sel[g]),
            .alumux1_sel (alumux1_sel[g]),
            .alumux2_sel (alumux2_sel[g]),
            .addrmux_sel (addrmux_sel[g]),
            .alu_op      (alu_op[g]),
            .instr_done  (instr_done[g]),
            .halted      (halted[g]),
            .fault       (fault[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_pass, n_checks);
        $fatal(1, "time limit");
    end

    function automatic out_t get_out(input int k);
        out_t r;
        r.mem_read     = mem_read[k];
        r.mem_write    = mem_write[k];
        r.load_pc      = load_pc[k];
        r.load_acc     = load_acc[k];
        r.load_regfile = load_regfile[k];
        r.load_ir      = load_ir[k];
        r.ir_byte_sel  = ir_byte_sel[k];
        r.pcmux_sel    = pcmux_sel[k];
        r.alumux1_sel  = alumux1_sel[k];
        r.alumux2_sel  = alumux2_sel[k];
        r.addrmux_sel  = addrmux_sel[k];
        r.alu_op       = alu_op[k];
        r.instr_done   = instr_done[k];
        r.halted       = halted[k];
        r.fault        = fault[k];
        return r;
    endfunction

    // Expected output vectors, written from the opcode/state tables
    function automatic out_t o_fetch(input logic resp, input logic [1:0] bsel);
        out_t e = '0;
        e.mem_read = 1'b1;
        if (resp) begin
            e.load_ir     = 1'b1;
            e.ir_byte_sel = bsel;
            e.load_pc     = 1'b1;
        end
        return e;
    endfunction

    function automatic out_t o_done();
        out_t e = '0;
        e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic out_t o_exec(input logic [3:0] op, input logic z);
        out_t e = '0;
        e.instr_done = 1'b1;
        case (op)
            4'h1: begin e.load_acc = 1'b1; e.alu_op = 3'd0; end
            4'h2: begin e.load_acc = 1'b1; e.alu_op = 3'd1; end
            4'h3: begin e.load_acc = 1'b1; e.alu_op = 3'd2; end
            4'h4: begin e.load_acc = 1'b1; e.alu_op = 3'd3; end
            4'h5: begin e.load_acc = 1'b1; e.alu_op = 3'd4; end
            4'h6: begin e.load_acc = 1'b1; e.alumux2_sel = 1'b1; e.alu_op = 3'd6; end
            4'h7: e.load_regfile = 1'b1;
            4'hA: begin e.load_pc = 1'b1; e.pcmux_sel = 1'b1; end
            4'hB: begin e.load_pc = z; e.pcmux_sel = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic out_t o_mem(input logic is_st, input logic resp);
        out_t e = '0;
        e.addrmux_sel = 2'd1;
        if (is_st) begin
            e.mem_write = 1'b1;
        end else begin
            e.mem_read = 1'b1;
            if (resp) begin
                e.load_acc    = 1'b1;
                e.alumux1_sel = 2'd2;
                e.alu_op      = 3'd5;
            end
        end
        e.instr_done = resp;
        return e;
    endfunction

    function automatic out_t o_halt();
        out_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    function automatic out_t o_fault();
        out_t e = '0;
        e.fault = 1'b1;
        return e;
    endfunction

    // Stimulus only: reset pulse spanning one rising edge, released between edges
    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_resp[k] = 1'b0;
            opcode[k]   = 4'h0;
            zero[k]     = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t it;
        out_t got;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_resp[k] = 1'b0;
            opcode[k]   = 4'h0;
            zero[k]     = 1'b0;
            sb.push_back('{inst: 2'(k), v: o_fetch(1'b0, 2'd0)});
        end
        @(negedge clk);
        while (sb.size() != 0) begin
            it  = sb.pop_front();
            got = get_out(int'(it.inst));
            n_checks++;
            if (got !== it.v) $display("FAIL reset: inst%0d got %h exp %h", it.inst, got, it.v);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alu_loop();
        logic [3:0] ops[9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'hA};
        exp_t it;
        out_t got;
        do_reset();
        mem_resp[0] = 1'b1;
        foreach (ops[i]) begin
            opcode[0] = ops[i];
            sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
            if (ops[i] == 4'h0) begin
                sb.push_back('{inst: 2'd0, v: o_done()});
            end else begin
                sb.push_back('{inst: 2'd0, v: '0});
                sb.push_back('{inst: 2'd0, v: o_exec(ops[i], 1'b0)});
            end
            while (sb.size() != 0) begin
                @(negedge clk);
                it  = sb.pop_front();
                got = get_out(int'(it.inst));
                n_checks++;
                if (got !== it.v) $display("FAIL alu_loop op%h: got %h exp %h", ops[i], got, it.v);
                else n_pass++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_ir_bytes();
        logic resp_seq[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_t it;
        out_t got;
        do_reset();
        opcode[1] = 4'h0;
        foreach (resp_seq[i]) begin
            mem_resp[1] = resp_seq[i];
            case (i)
                0: sb.push_back('{inst: 2'd1, v: o_fetch(1'b1, 2'd0)});
                1: sb.push_back('{inst: 2'd1, v: o_fetch(1'b0, 2'd0)});
                2: sb.push_back('{inst: 2'd1, v: o_fetch(1'b1, 2'd1)});
                3: sb.push_back('{inst: 2'd1, v: o_fetch(1'b1, 2'd2)});
                4: sb.push_back('{inst: 2'd1, v: o_done()});
                default: sb.push_back('{inst: 2'd1, v: o_fetch(1'b1, 2'd0)});
            endcase
            @(negedge clk);
            it  = sb.pop_front();
            got = get_out(int'(it.inst));
            n_checks++;
            if (got !== it.v) $display("FAIL ir_bytes cyc%0d: got %h exp %h", i, got, it.v);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_delay();
        exp_t it;
        out_t got;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            case (s)
                0: begin
                    opcode[0] = 4'h8; mem_resp[0] = 1'b1;
                    sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
                    sb.push_back('{inst: 2'd0, v: '0});
                end
                1: begin
                    mem_resp[0] = 1'b0;
                    for (int j = 0; j < 5; j++) sb.push_back('{inst: 2'd0, v: o_mem(1'b0, 1'b0)});
                end
                2: begin
                    mem_resp[0] = 1'b1;
                    sb.push_back('{inst: 2'd0, v: o_mem(1'b0, 1'b1)});
                end
                3: begin
                    opcode[0] = 4'h9;
                    sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
                    sb.push_back('{inst: 2'd0, v: '0});
                end
                4: begin
                    mem_resp[0] = 1'b0;
                    sb.push_back('{inst: 2'd0, v: o_mem(1'b1, 1'b0)});
                    sb.push_back('{inst: 2'd0, v: o_mem(1'b1, 1'b0)});
                end
                5: begin
                    mem_resp[0] = 1'b1;
                    sb.push_back('{inst: 2'd0, v: o_mem(1'b1, 1'b1)});
                end
                default: begin
                    mem_resp[0] = 1'b0;
                    sb.push_back('{inst: 2'd0, v: o_fetch(1'b0, 2'd0)});
                end
            endcase
            while (sb.size() != 0) begin
                @(negedge clk);
                it  = sb.pop_front();
                got = get_out(int'(it.inst));
                n_checks++;
                if (got !== it.v) $display("FAIL mem_delay seg%0d: got %h exp %h", s, got, it.v);
                else n_pass++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_timeout();
        exp_t it;
        out_t got;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0: begin
                    do_reset();
                    for (int j = 0; j < 5; j++) sb.push_back('{inst: 2'd2, v: o_fetch(1'b0, 2'd0)});
                    for (int j = 0; j < 3; j++) sb.push_back('{inst: 2'd2, v: o_fault()});
                end
                1: begin
                    mem_resp[2] = 1'b1;
                    sb.push_back('{inst: 2'd2, v: o_fault()});
                    sb.push_back('{inst: 2'd2, v: o_fault()});
                end
                2: begin
                    do_reset();
                    for (int j = 0; j < 4; j++) sb.push_back('{inst: 2'd2, v: o_fetch(1'b0, 2'd0)});
                end
                3: begin
                    mem_resp[2] = 1'b1;
                    sb.push_back('{inst: 2'd2, v: o_fetch(1'b1, 2'd0)});
                    sb.push_back('{inst: 2'd2, v: o_done()});
                end
                default: begin
                    mem_resp[2] = 1'b0;
                    sb.push_back('{inst: 2'd2, v: o_fetch(1'b0, 2'd0)});
                end
            endcase
            while (sb.size() != 0) begin
                @(negedge clk);
                it  = sb.pop_front();
                got = get_out(int'(it.inst));
                n_checks++;
                if (got !== it.v) $display("FAIL timeout seg%0d: got %h exp %h", s, got, it.v);
                else n_pass++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_brz_halt();
        exp_t it;
        out_t got;
        do_reset();
        mem_resp[0] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0, 1: begin
                    opcode[0] = 4'hB;
                    zero[0]   = (s == 1);
                    sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
                    sb.push_back('{inst: 2'd0, v: '0});
                    sb.push_back('{inst: 2'd0, v: o_exec(4'hB, (s == 1))});
                end
                2: begin
                    opcode[0] = 4'hC;
                    sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
                    sb.push_back('{inst: 2'd0, v: o_done()});
                    for (int j = 0; j < 3; j++) sb.push_back('{inst: 2'd0, v: o_halt()});
                end
                3: begin
                    opcode[0] = 4'h1;
                    zero[0]   = 1'b0;
                    sb.push_back('{inst: 2'd0, v: o_halt()});
                    sb.push_back('{inst: 2'd0, v: o_halt()});
                end
                default: begin
                    do_reset();
                    sb.push_back('{inst: 2'd0, v: o_fetch(1'b0, 2'd0)});
                end
            endcase
            while (sb.size() != 0) begin
                @(negedge clk);
                it  = sb.pop_front();
                got = get_out(int'(it.inst));
                n_checks++;
                if (got !== it.v) $display("FAIL brz_halt seg%0d: got %h exp %h", s, got, it.v);
                else n_pass++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_illegal_async_reset();
        exp_t it;
        out_t got;
        do_reset();
        opcode[0]   = 4'hD;
        mem_resp[0] = 1'b1;
        sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
        sb.push_back('{inst: 2'd0, v: '0});
        sb.push_back('{inst: 2'd0, v: o_fault()});
        sb.push_back('{inst: 2'd0, v: o_fault()});
        while (sb.size() != 0) begin
            @(negedge clk);
            it  = sb.pop_front();
            got = get_out(int'(it.inst));
            n_checks++;
            if (got !== it.v) $display("FAIL illegal: got %h exp %h", got, it.v);
            else n_pass++;
            @(posedge clk);
            #1;
        end

        do_reset();
        opcode[0]   = 4'h9;
        mem_resp[0] = 1'b1;
        sb.push_back('{inst: 2'd0, v: o_fetch(1'b1, 2'd0)});
        sb.push_back('{inst: 2'd0, v: '0});
        while (sb.size() != 0) begin
            @(negedge clk);
            it  = sb.pop_front();
            got = get_out(int'(it.inst));
            n_checks++;
            if (got !== it.v) $display("FAIL st_setup: got %h exp %h", got, it.v);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        mem_resp[0] = 1'b0;
        sb.push_back('{inst: 2'd0, v: o_mem(1'b1, 1'b0)});
        @(negedge clk);
        it  = sb.pop_front();
        got = get_out(int'(it.inst));
        n_checks++;
        if (got !== it.v) $display("FAIL st_wait: got %h exp %h", got, it.v);
        else n_pass++;
        // reset lands between clock edges; outputs must react without a clock
        #2;
        rst_n = 1'b0;
        sb.push_back('{inst: 2'd0, v: o_fetch(1'b0, 2'd0)});
        #1;
        it  = sb.pop_front();
        got = get_out(int'(it.inst));
        n_checks++;
        if (got !== it.v) $display("FAIL async_reset: got %h exp %h", got, it.v);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back('{inst: 2'd0, v: o_fetch(1'b0, 2'd0)});
        @(negedge clk);
        it  = sb.pop_front();
        got = get_out(int'(it.inst));
        n_checks++;
        if (got !== it.v) $display("FAIL post_reset: got %h exp %h", got, it.v);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            opcode[k]   = 4'h0;
            zero[k]     = 1'b0;
            mem_resp[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_alu_loop();
        test_ir_bytes();
        test_mem_delay();
        test_timeout();
        test_brz_halt();
        test_illegal_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
